// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port switch arbiter.
//   PORTn_SOURCE : one-hot source identifiers
//   slot_state_t : per-ingress buffer slot state
//   pkt_t        : buffered packet (source, original target mask, payload)
package switch_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [3:0] PORT0_SOURCE = 4'b0001;
  localparam logic [3:0] PORT1_SOURCE = 4'b0010;
  localparam logic [3:0] PORT2_SOURCE = 4'b0100;
  localparam logic [3:0] PORT3_SOURCE = 4'b1000;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] dat;
  } pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter for one egress port.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[3:0]   : requesting slots
//   gnt[3:0]   : one-hot grant, zero when nothing requests
// The pointer holds the last granted index; the search starts one above it.
// Reset value 3 gives slot 0 first priority.
module rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt
);

  logic [1:0] ptr;
  logic [1:0] gnt_idx;
  logic [1:0] idx;

  // Walk from the lowest to the highest priority offset so the last hit,
  // i.e. the nearest requester above ptr, is the one that sticks.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    idx     = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd3;
    end else if (|req) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Ingress buffering, multicast expansion and per-egress round-robin sharing
// for the 4-port switch.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid[i]    : packet strobe from ingress i (one cycle per packet)
//   in_source/in_target/in_data : per-ingress fields, slice i = [W*i +: W]
//   in_ready[i]    : slot i accepts a packet this cycle
//   out_valid[j]   : registered valid on egress j
//   out_source/out_target/out_data : packet on egress j (held when idle)
//   drop_count     : saturating count of packets hitting a busy slot
//   illegal_count  : saturating count of packets with no effective target
module switch_arbiter #(
  parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [4*NUM_PORTS-1:0] in_source,
  input  logic [4*NUM_PORTS-1:0] in_target,
  input  logic [8*NUM_PORTS-1:0] in_data,
  output logic [NUM_PORTS-1:0]   in_ready,
  output logic [NUM_PORTS-1:0]   out_valid,
  output logic [4*NUM_PORTS-1:0] out_source,
  output logic [4*NUM_PORTS-1:0] out_target,
  output logic [8*NUM_PORTS-1:0] out_data,
  output logic [CNT_W-1:0]       drop_count,
  output logic [CNT_W-1:0]       illegal_count
);
  import switch_pkg::*;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  slot_state_t state     [NUM_PORTS];
  slot_state_t state_nxt [NUM_PORTS];
  pkt_t        pkt       [NUM_PORTS];
  logic [3:0]  rem       [NUM_PORTS];
  logic [3:0]  rem_nxt   [NUM_PORTS];
  logic [3:0]  eff       [NUM_PORTS];
  logic [3:0]  won       [NUM_PORTS];  // won[i][j]: slot i granted on egress j
  logic [3:0]  req       [NUM_PORTS];  // req[j][i]: slot i wants egress j
  logic [3:0]  gnt       [NUM_PORTS];  // gnt[j][i]: egress j grants slot i
  pkt_t        sel       [NUM_PORTS];
  logic [NUM_PORTS-1:0] cap;
  logic [2:0]  n_drop;
  logic [2:0]  n_ill;

  // Request / grant cross-bar between slots and egress arbiters.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[j][i] = (state[i] == PENDING) && rem[i][j];
        won[i][j] = gnt[j][i];
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_arbiter u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req[j]),
      .gnt   (gnt[j])
    );
  end

  // A slot is reusable in the same cycle its last outstanding copy is granted.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eff[i]      = in_target[4*i +: 4] & ~(4'(1) << i);
      in_ready[i] = (state[i] == EMPTY) || ((rem[i] & ~won[i]) == 4'b0000);
    end
  end

  always_comb begin
    cap    = '0;
    n_drop = '0;
    n_ill  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_nxt[i] = state[i];
      rem_nxt[i]   = rem[i];
      if (state[i] == PENDING) begin
        rem_nxt[i] = rem[i] & ~won[i];
        if (rem_nxt[i] == 4'b0000) state_nxt[i] = EMPTY;
      end
      // A capture overrides the free: the new packet takes the slot.
      if (in_valid[i] && in_ready[i] && eff[i] != 4'b0000) begin
        cap[i]       = 1'b1;
        state_nxt[i] = PENDING;
        rem_nxt[i]   = eff[i];
      end
      n_drop = n_drop + 3'(in_valid[i] & ~in_ready[i]);
      n_ill  = n_ill  + 3'(in_valid[i] & in_ready[i] & (eff[i] == 4'b0000));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state[i] <= EMPTY;
        rem[i]   <= '0;
      end
      drop_count    <= '0;
      illegal_count <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state[i] <= state_nxt[i];
        rem[i]   <= rem_nxt[i];
      end
      drop_count    <= sat_add(drop_count, n_drop);
      illegal_count <= sat_add(illegal_count, n_ill);
    end
  end

  // Packet contents are only meaningful while the slot is PENDING.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cap[i]) begin
        pkt[i] <= '{src: in_source[4*i +: 4], tgt: in_target[4*i +: 4],
                    dat: in_data[8*i +: 8]};
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      sel[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[j][i]) sel[j] = pkt[i];
      end
    end
  end

  // Egress output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= '0;
      out_source <= '0;
      out_target <= '0;
      out_data   <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_valid[j] <= |gnt[j];
        if (|gnt[j]) begin
          out_source[4*j +: 4] <= sel[j].src;
          out_target[4*j +: 4] <= sel[j].tgt;
          out_data[8*j +: 8]   <= sel[j].dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter with a behavioural reference model and
// hand-computed literal expectations.
module tb_switch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  in_valid;
  logic [15:0] in_source;
  logic [15:0] in_target;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [15:0] out_source;
  logic [15:0] out_target;
  logic [31:0] out_data;
  logic [7:0]  drop_count;
  logic [7:0]  illegal_count;

  switch_arbiter #(.NUM_PORTS(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_source     (in_source),
    .in_target     (in_target),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_source    (out_source),
    .out_target    (out_target),
    .out_data      (out_data),
    .drop_count    (drop_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit         m_pend [4];
  logic [3:0] m_src  [4];
  logic [3:0] m_tgt  [4];
  logic [3:0] m_rem  [4];
  logic [7:0] m_dat  [4];
  int         m_ptr  [4];
  logic [3:0]  m_ov;
  logic [15:0] m_os, m_ot;
  logic [31:0] m_od;
  int          m_drop, m_ill;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_rem[i] = 0; m_ptr[i] = 3;
    end
    m_ov = 0; m_os = 0; m_ot = 0; m_od = 0; m_drop = 0; m_ill = 0;
  endtask

  // Nearest pending requester of egress j after its last grantee, or -1.
  function automatic int grant_of(input int j);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_ptr[j] + k) % 4;
      if (m_pend[idx] && m_rem[idx][j]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] left;
      left = m_rem[i];
      for (int j = 0; j < 4; j++) if (grant_of(j) == i) left[j] = 1'b0;
      r[i] = !m_pend[i] || (left == 4'b0000);
    end
    return r;
  endfunction

  task automatic model_step();
    int g [4];
    logic [3:0] rdy;
    rdy = exp_ready();
    for (int j = 0; j < 4; j++) g[j] = grant_of(j);
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i]) begin
        if (!rdy[i]) m_drop = (m_drop + 1 > 255) ? 255 : m_drop + 1;
        else if ((in_target[4*i +: 4] & ~(4'b0001 << i)) == 0)
          m_ill = (m_ill + 1 > 255) ? 255 : m_ill + 1;
      end
    end
    for (int j = 0; j < 4; j++) begin
      m_ov[j] = (g[j] >= 0);
      if (g[j] >= 0) begin
        m_os[4*j +: 4] = m_src[g[j]];
        m_ot[4*j +: 4] = m_tgt[g[j]];
        m_od[8*j +: 8] = m_dat[g[j]];
        m_ptr[j] = g[j];
        m_rem[g[j]][j] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] e;
      if (m_pend[i] && m_rem[i] == 0) m_pend[i] = 0;
      e = in_target[4*i +: 4] & ~(4'b0001 << i);
      if (in_valid[i] && rdy[i] && e != 0) begin
        m_pend[i] = 1;
        m_rem[i]  = e;
        m_src[i]  = in_source[4*i +: 4];
        m_tgt[i]  = in_target[4*i +: 4];
        m_dat[i]  = in_data[8*i +: 8];
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", out_valid, m_ov);
      chk("in_ready", in_ready, exp_ready());
      chk("out_fields", {out_source, out_target, out_data}, {m_os, m_ot, m_od});
      chk("drop_count", drop_count, m_drop[7:0]);
      chk("illegal_count", illegal_count, m_ill[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    in_valid = 0; in_source = 0; in_target = 0; in_data = 0;
  endtask

  task automatic drive(input int p, input logic [3:0] tgt, input logic [7:0] d);
    in_valid[p]        = 1'b1;
    in_source[4*p +: 4] = 4'b0001 << p;
    in_target[4*p +: 4] = tgt;
    in_data[8*p +: 8]   = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_ready", in_ready, 4'b1111);
    chk("rst_counts", {drop_count, illegal_count}, 16'h0000);
    rst_n = 1'b1;

    // Unicast
    drive(0, 4'b0100, 8'hA5);
    @(negedge clk); clear_in();
    chk("uni_ready0", in_ready[0], 1'b1);
    @(negedge clk);
    chk("uni_valid", out_valid, 4'b0100);
    chk("uni_src", out_source[11:8], 4'b0001);
    chk("uni_data", out_data[23:16], 8'hA5);

    // Multicast
    drive(1, 4'b1101, 8'h3C);
    @(negedge clk); clear_in();
    @(negedge clk);
    chk("mc_valid", out_valid, 4'b1101);
    chk("mc_src0", out_source[3:0], 4'b0010);
    chk("mc_data3", out_data[31:24], 8'h3C);
    chk("mc_ready1", in_ready[1], 1'b1);
    @(negedge clk);
    chk("mc_done", out_valid, 4'b0000);

    // Contention on egress 2, twice
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 0) do_reset();
      drive(0, 4'b0100, 8'h11); drive(1, 4'b0100, 8'h22); drive(3, 4'b0100, 8'h33);
      @(negedge clk); clear_in();
      @(negedge clk);
      chk("cont_first", {out_source[11:8], out_data[23:16]}, {4'b0001, 8'h11});
      @(negedge clk);
      chk("cont_second", {out_source[11:8], out_data[23:16]}, {4'b0010, 8'h22});
      @(negedge clk);
      chk("cont_third", {out_source[11:8], out_data[23:16]}, {4'b1000, 8'h33});
    end
    @(negedge clk);
    chk("cont_idle", out_valid, 4'b0000);

    // Busy drop on slot 2
    do_reset();
    drive(1, 4'b0001, 8'h51); drive(2, 4'b0001, 8'h52); drive(3, 4'b0001, 8'h53);
    @(negedge clk); clear_in();
    chk("drop_ready", in_ready, 4'b0011);
    drive(2, 4'b0001, 8'h99);
    @(negedge clk); clear_in();
    chk("drop_cnt", drop_count, 8'd1);
    chk("drop_d1", out_data[7:0], 8'h51);
    @(negedge clk);
    chk("drop_d2", out_data[7:0], 8'h52);
    @(negedge clk);
    chk("drop_d3", {out_valid, out_data[7:0]}, {4'b0001, 8'h53});
    @(negedge clk);
    chk("drop_idle", out_valid, 4'b0000);

    // Illegal targets and saturation
    do_reset();
    drive(3, 4'b1000, 8'h01);
    @(negedge clk);
    drive(3, 4'b0000, 8'h02);
    @(negedge clk); clear_in();
    chk("ill_two", illegal_count, 8'd2);
    chk("ill_novalid", out_valid, 4'b0000);
    for (int p = 0; p < 4; p++) drive(p, 4'b0001 << p, 8'h00);
    @(negedge clk); clear_in();
    chk("ill_six", illegal_count, 8'd6);
    for (int c = 0; c < 64; c++) begin
      for (int p = 0; p < 4; p++) drive(p, 4'b0001 << p, 8'h00);
      @(negedge clk);
    end
    clear_in();
    chk("ill_sat", illegal_count, 8'hFF);
    chk("ill_nodrop", drop_count, 8'd0);
    @(negedge clk);
    chk("ill_hold", illegal_count, 8'hFF);

    // Reset mid-operation
    drive(1, 4'b0001, 8'h61); drive(2, 4'b0001, 8'h62); drive(3, 4'b0001, 8'h63);
    @(negedge clk); clear_in();
    @(posedge clk); #1;
    chk("mid_pre", out_valid, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 4'b0000);
    chk("mid_fields", {out_source, out_target, out_data}, 64'h0);
    chk("mid_ready", in_ready, 4'b1111);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", out_valid, 4'b0000);
    end
    drive(0, 4'b0110, 8'hAA); drive(3, 4'b0110, 8'hBB);
    @(negedge clk); clear_in();
    @(negedge clk);
    chk("post_first", {out_valid, out_source[7:4], out_source[11:8]}, {4'b0110, 4'b0001, 4'b0001});
    @(negedge clk);
    chk("post_second", {out_data[15:8], out_data[23:16]}, {8'hBB, 8'hBB});

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
Name: switch_arbiter

Overview:
- Sits between the four per-port ingress FSMs and the four egress ports of the 4-port switch.
- Buffers one packet per ingress port and expands multicast one-hot targets into per-egress copies.
- Shares each egress port between contending ingress ports with an independent round-robin arbiter.
- Reports dropped and illegal packets through saturating counters.

Parameters:
- NUM_PORTS, 4, number of ingress/egress ports. Fixed at 4; source and target fields are 4-bit one-hot.
- CNT_W, 8, width of the drop and illegal counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_PORTS  per-ingress packet strobe, one cycle per packet
- in_source  in  4*NUM_PORTS  per-ingress one-hot source; slice i = bits [4i+3:4i]
- in_target  in  4*NUM_PORTS  per-ingress one-hot/multicast target mask
- in_data  in  8*NUM_PORTS  per-ingress payload
- in_ready  out  NUM_PORTS  slot i can accept a packet this cycle
- out_valid  out  NUM_PORTS  per-egress registered valid
- out_source  out  4*NUM_PORTS  source of the packet on egress j
- out_target  out  4*NUM_PORTS  original target mask of that packet
- out_data  out  8*NUM_PORTS  payload on egress j
- drop_count  out  CNT_W  saturating count of packets lost to a busy slot
- illegal_count  out  CNT_W  saturating count of packets with an empty effective target

Behaviour:
- Reset (rst_n low, asynchronous):
  - all slots go to EMPTY;
  - out_valid=0; out_source/out_target/out_data=0;
  - counters=0; all round-robin pointers=3, so port 0 has first priority.
- Slot FSM, one per ingress i:
  - States: EMPTY, PENDING.
  - Slot registers: src, tgt, dat, rem (remaining egress mask).
- Effective target = in_target[i] with bit i cleared. No loopback.
- Capture: when in_valid[i] && in_ready[i] && effective target != 0:
  - latch src, tgt (original mask), dat;
  - set rem = effective target;
  - go to PENDING.
- Illegal: when in_valid[i] && in_ready[i] && effective target == 0:
  - the packet is not stored;
  - illegal_count += 1, saturating at all-ones.
- Drop: when in_valid[i] && !in_ready[i]:
  - the packet is discarded;
  - drop_count += 1, saturating.
  - Simultaneous drops or illegals on several ports add their full number, still saturating.
- in_ready[i] = (slot EMPTY) || (slot PENDING && every remaining bit of rem is granted this cycle). This is combinational, so back-to-back reuse costs zero bubbles.
- Arbitration, one per egress j, each cycle:
  - Requesters are all slots with state PENDING and rem[j]=1.
  - Grant goes to the first requester found searching upward from ptr[j]+1, modulo 4.
  - ptr[j] updates to the granted index only when a grant occurs.
- Grant effects at the clock edge:
  - out_valid[j]=1, out_source/out_target/out_data = granted slot's src/tgt/dat;
  - rem bit j cleared in the granted slot.
  - With no grant: out_valid[j]=0 and the data outputs hold their last value.
- A slot returns to EMPTY at the edge where its rem becomes 0. A slot may be granted on several egresses in the same cycle.
- Latency: in_valid at edge N (capture) gives out_valid visible after edge N+1 when uncontended. Each extra contender ahead in round-robin order adds one cycle.
- Capture and free in the same cycle: the new packet overwrites the slot and state stays PENDING with the new rem.
- Reset mid-operation discards all pending packets. No partial multicast resumes after reset.

Decomposition:
- Shared package switch_pkg holds:
  - PORT0..PORT3_SOURCE one-hot constants;
  - slot_state_t (EMPTY, PENDING);
  - packed struct pkt_t {src[3:0], tgt[3:0], dat[7:0]};
  - NUM_PORTS default.
- Sub-module rr_arbiter (req[3:0] -> gnt one-hot, pointer register inside, updates on any grant). Instantiated once per egress.

Test Plan:
- Unicast: port0 in_valid, target 0100, data A5 -> one cycle after capture, out_valid[2]=1 with source 0001, data A5; in_ready[0]=1 again the same cycle.
- Multicast: port1 target 1101, data 3C -> egress 0, 2 and 3 valid in the same cycle with source 0010; slot1 EMPTY afterwards.
- Contention: ports 0, 1 and 3 all target 0100 in the same cycle after reset -> egress 2 grants 0, 1, 3 in consecutive cycles. A repeat burst starts from port 0 again, since ptr=3 after the last grant.
- Busy drop: port2 sends target 0001 while a held slot still has rem pending (egress 0 contended) -> drop_count increments by 1; the original packet is still delivered.
- Illegal: port3 sends target 1000 (self only), then target 0000 -> illegal_count=2, no out_valid; drive 260 illegals -> count saturates at FF.
- Reset mid-operation: assert rst_n low while 3 slots are PENDING -> all outputs 0 immediately, no out_valid after release; the first post-reset grant on each egress goes to port 0.
